// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver feeding a valid/ready byte stream.
// RsRx passes through a SYNC_STAGES-deep synchroniser, whose flops are preset
// to idle-high. A mid-bit sampling FSM then deserialises the frame.
// Optional build macro UART_RX_PARITY_EN: when defined, the frame is 8E1 and a
// parity_err pulse output is added.
// Handshake: rx_valid means rx_data holds an unconsumed byte. The byte is taken
// on any rising edge where rx_valid && rx_ready. A byte that completes while
// rx_valid is already high overwrites rx_data. If that happens without a
// simultaneous accept, overrun pulses.
// dbg_state exposes the FSM state encoding for observation.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RsRx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic            rxs;

  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            load;
  logic            fe_set;

`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            parity_err_q, parity_err_d;
  logic            pe_set;
`endif

  assign rxs = sync_q[SYNC_STAGES-1];

  // Metastability synchroniser; presets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], RsRx};
  end

  // FSM and deserialiser state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: sample at mid start bit, then once per bit period.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    load    = 1'b0;
    fe_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_set  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (bcnt_q == HALF_LAST) begin
          bcnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = 3'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d          = '0;
          shift_d[idx_q]  = rxs;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d  = '0;
          par_d   = rxs;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
          pe_set = (par_q != ^shift_q);
`endif
          if (rxs) begin
            load    = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        bcnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        bcnt_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output stage: load and handshake for rx_data/rx_valid, plus the one-cycle error pulses.
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = 1'b0;
    frame_err_d = fe_set;
`ifdef UART_RX_PARITY_EN
    parity_err_d = pe_set;
`endif
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (load) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q && !rx_ready;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: bench for uart_rx_byte at CLKS_PER_BIT=16 with a 10 ns clock.
// The reference model is a per-frame rule: a frame with a high stop bit delivers
// its byte, and a frame with a low stop bit yields one frame_err. Delivered bytes
// are compared against an expected queue.
module tb_uart_rx_byte;

  localparam int CLKS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RsRx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .RsRx(RsRx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and counters.
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  time start_t = 0;
  time rise_t = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
    if (rx_valid && !prev_valid) rise_t = $time;
    prev_valid = rx_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare delivered bytes against the scoreboard, then empty both queues.
  task automatic chk_sb(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_byte"}, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic bit_out(input logic v);
    RsRx = v;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    RsRx = 1'b1;
    repeat (n * CLKS) @(posedge clk);
    #1;
  endtask

  // One frame: start, 8 data bits LSB first, optional even parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    @(posedge clk);
    #1;
    start_t = $time;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    bit_out(stop_bit);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         gap;
    int         exp_bytes;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h00, 1'b1, 0, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 1, 1, 0};
    vecs[2] = '{8'h5A, 1'b0, 2, 0, 1};
    vecs[3] = '{8'h80, 1'b1, 1, 1, 0};
    vecs[4] = '{8'h01, 1'b1, 0, 1, 0};
    vecs[5] = '{8'hC3, 1'b1, 1, 1, 0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_data", {24'h0, rx_data}, 32'h0);
    chk("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);
    chk("reset_overrun", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;
    idle_bits(2);

    // A5 with rx_ready low: latency, hold, then a single-cycle accept.
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_bits(1);
    chk("a5_latency_lo", {31'h0, (rise_t - start_t) >= time'((19 + 2 * PBITS) * CLKS * 5)}, 32'h1);
    chk("a5_latency_hi", {31'h0, (rise_t - start_t) <= time'((19 + 2 * PBITS) * CLKS * 5 + 60)}, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    chk("a5_valid_hold", {31'h0, rx_valid}, 32'h1);
    chk("a5_data", {24'h0, rx_data}, 32'hA5);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    chk("a5_valid_clear", {31'h0, rx_valid}, 32'h0);
    exp_q.push_back(8'hA5);
    chk_sb("a5");

    // Table-driven frames with rx_ready tied high.
    rx_ready = 1'b1;
    foreach (vecs[k]) begin
      fe_cnt = 0;
      ov_cnt = 0;
      send_frame(vecs[k].data, vecs[k].stop_ok, 1'b0);
      idle_bits(vecs[k].gap);
      if (vecs[k].gap == 0) begin
        @(posedge clk);
        #1;
      end
      chk("vec_bytes", got_q.size(), vecs[k].exp_bytes);
      if (vecs[k].exp_bytes == 1 && got_q.size() == 1)
        chk("vec_data", {24'h0, got_q[0]}, {24'h0, vecs[k].data});
      chk("vec_fe", fe_cnt, vecs[k].exp_fe);
      chk("vec_ov", ov_cnt, 0);
      got_q.delete();
    end
    idle_bits(1);

    // 40 ns glitch is rejected, then 3C is received.
    fe_cnt = 0;
    RsRx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle_bits(3);
    chk("glitch_valid", {31'h0, rx_valid}, 32'h0);
    chk("glitch_fe", fe_cnt, 0);
    chk("glitch_bytes", got_q.size(), 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle_bits(1);
    exp_q.push_back(8'h3C);
    chk_sb("glitch_next");

    // 55 with a low stop bit and a held-low line gives exactly one frame_err.
    fe_cnt = 0;
    send_frame(8'h55, 1'b0, 1'b0);
    RsRx = 1'b0;
    repeat (5 * CLKS) @(posedge clk);
    #1;
    idle_bits(2);
    chk("break_fe_once", fe_cnt, 1);
    chk("break_valid", {31'h0, rx_valid}, 32'h0);
    chk("break_bytes", got_q.size(), 0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle_bits(1);
    exp_q.push_back(8'h81);
    chk_sb("break_next");

    // Overrun: 11 then 22 with rx_ready low.
    rx_ready = 1'b0;
    ov_cnt = 0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle_bits(1);
    chk("ovr_pulse", ov_cnt, 1);
    chk("ovr_data", {24'h0, rx_data}, 32'h22);
    chk("ovr_valid", {31'h0, rx_valid}, 32'h1);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(8'h22);
    chk_sb("ovr_accept");

    // Mid-byte reset with a pending byte: outputs clear at once, and only 7E is delivered.
    rx_ready = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0);
    idle_bits(1);
    @(posedge clk);
    #1;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_data", {24'h0, rx_data}, 32'h0);
    RsRx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bits(2);
    rx_ready = 1'b1;
    send_frame(8'h7E, 1'b1, 1'b0);
    idle_bits(1);
    exp_q.push_back(8'h7E);
    chk_sb("rst_next");

`ifdef UART_RX_PARITY_EN
    // Parity mismatch still delivers the byte.
    pe_cnt = 0;
    send_frame(8'h03, 1'b1, 1'b1);
    idle_bits(1);
    chk("par_err", pe_cnt, 1);
    exp_q.push_back(8'h03);
    chk_sb("par_byte");
`endif

    // Randomized frames against the frame-level reference model.
    begin
      int exp_fe;
      exp_fe = 0;
      fe_cnt = 0;
      ov_cnt = 0;
      pe_cnt = 0;
      for (int n = 0; n < 24; n++) begin
        logic [7:0] d;
        logic stop_ok;
        d = 8'($urandom);
        stop_ok = ($urandom_range(0, 4) != 0);
        send_frame(d, stop_ok, 1'b0);
        if (stop_ok) exp_q.push_back(d);
        else exp_fe++;
        idle_bits(stop_ok ? $urandom_range(0, 2) : $urandom_range(1, 2));
      end
      idle_bits(1);
      chk_sb("rand");
      chk("rand_fe", fe_cnt, exp_fe);
      chk("rand_ov", ov_cnt, 0);
      chk("rand_pe", pe_cnt, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #20ms;
    $display("FAIL timeout: simulation exceeded its time limit");
    n_mis++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $fatal(1, "timeout");
  end

endmodule
